// File: rtl/mem_bridge_if.sv
// CPU-side and memory-side signal bundle for mem_bridge.
// The master modport is the bridge itself; slave is the CPU plus memory around it.
interface mem_bridge_if #(
  parameter int DEPTH = 4
);
  logic                   cpu_req;
  logic                   cpu_rw;
  logic [31:0]            cpu_addr;
  logic [31:0]            cpu_wdata;
  logic [31:0]            cpu_rdata;
  logic                   cpu_stall;

  logic                   mem_valid;
  logic                   mem_ready;
  logic                   mem_we;
  logic [31:0]            mem_addr;
  logic [31:0]            mem_wdata;
  logic                   mem_rvalid;
  logic [31:0]            mem_rdata;

  logic [$clog2(DEPTH):0] wbuf_level;
  logic                   err;

  modport master (
    input  cpu_req, cpu_rw, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    output mem_valid, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output wbuf_level, err
  );

  modport slave (
    output cpu_req, cpu_rw, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    input  mem_valid, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  wbuf_level, err
  );
endinterface

// File: rtl/mem_bridge.sv
// mem_bridge: posted-write buffer plus stalling, timeout-guarded read path to external memory.
// Define MEM_BRIDGE_FWD_EN to serve reads that hit a buffered write straight from the buffer.
module mem_bridge #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input logic          clock,
  input logic          reset,
  mem_bridge_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL     = LW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [7:0]    TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    RREQ,
    RWAIT,
    RDONE
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [LW-1:0] level_q, level_d;
  logic [7:0]    timer_q, timer_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          memValid_q, memValid_d;
  logic          memWe_q, memWe_d;
  logic [31:0]   memAddr_q, memAddr_d;
  logic [31:0]   memWdata_q, memWdata_d;

  logic [31:0]   bufAddr [DEPTH];
  logic [31:0]   bufData [DEPTH];

  logic          isWrite;
  logic          isRead;
  logic          full;
  logic          push;
  logic          pop;

  assign isWrite = bus.cpu_req & bus.cpu_rw;
  assign isRead  = bus.cpu_req & ~bus.cpu_rw;
  assign full    = (level_q == FULL);
  assign push    = isWrite & ~full;
  assign pop     = memValid_q & memWe_q & bus.mem_ready;

  // Stall is the only combinational output; gating with reset keeps it low while in reset.
  assign bus.cpu_stall = reset & ((isWrite & full) | (isRead & (state_q != RDONE)));

`ifdef MEM_BRIDGE_FWD_EN
  logic          fwdHit;
  logic [31:0]   fwdData;

  // Scan oldest to newest so the newest matching entry wins.
  always_comb begin
    logic [PW-1:0] idx;
    fwdHit  = 1'b0;
    fwdData = '0;
    idx     = rdPtr_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rdPtr_q + PW'(i);
      if ((LW'(i) < level_q) && (bufAddr[idx] == bus.cpu_addr)) begin
        fwdHit  = 1'b1;
        fwdData = bufData[idx];
      end
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    timer_d    = timer_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    memValid_d = 1'b0;
    memWe_d    = 1'b0;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;

    if (push) wrPtr_d = wrPtr_q + PTR_ONE;
    if (pop)  rdPtr_d = rdPtr_q + PTR_ONE;
    level_d = level_q + LW'(push) - LW'(pop);

    case (state_q)
      IDLE: begin
        if (isRead) begin
`ifdef MEM_BRIDGE_FWD_EN
          if (fwdHit) begin
            state_d = RDONE;
            rdata_d = fwdData;
          end else if (level_q != '0) begin
            state_d = DRAIN;
          end else begin
            state_d = RREQ;
          end
`else
          if (level_q != '0) state_d = DRAIN;
          else               state_d = RREQ;
`endif
        end
      end
      DRAIN: begin
        if (level_q == '0) state_d = RREQ;
      end
      RREQ: begin
        if (memValid_q & ~memWe_q & bus.mem_ready) begin
          state_d = RWAIT;
          timer_d = '0;
        end
      end
      RWAIT: begin
        if (bus.mem_rvalid) begin
          rdata_d = bus.mem_rdata;
          state_d = RDONE;
        end else if (timer_q == TMO_LAST) begin
          rdata_d = 32'hDEAD_BEEF;
          err_d   = 1'b1;
          state_d = RDONE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      RDONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Bus outputs are registered, so they are derived from the next buffer/FSM state;
    // an entry pushed into an otherwise empty buffer is taken straight from the CPU.
    if (state_d == RREQ) begin
      memValid_d = 1'b1;
      memWe_d    = 1'b0;
      memAddr_d  = bus.cpu_addr;
    end else if ((state_d != RWAIT) && (level_d != '0)) begin
      memValid_d = 1'b1;
      memWe_d    = 1'b1;
      if (push && (wrPtr_q == rdPtr_d)) begin
        memAddr_d  = bus.cpu_addr;
        memWdata_d = bus.cpu_wdata;
      end else begin
        memAddr_d  = bufAddr[rdPtr_d];
        memWdata_d = bufData[rdPtr_d];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      bufAddr[wrPtr_q] <= bus.cpu_addr;
      bufData[wrPtr_q] <= bus.cpu_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      level_q    <= '0;
      timer_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      memValid_q <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
    end else begin
      state_q    <= state_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      level_q    <= level_d;
      timer_q    <= timer_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      memValid_q <= memValid_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
    end
  end

  assign bus.cpu_rdata  = rdata_q;
  assign bus.mem_valid  = memValid_q;
  assign bus.mem_we     = memWe_q;
  assign bus.mem_addr   = memAddr_q;
  assign bus.mem_wdata  = memWdata_q;
  assign bus.wbuf_level = level_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Directed self-checking bench for mem_bridge (DEPTH=4, TIMEOUT=8).
// Inputs change 2 time units after the rising edge; checks land 1 unit later.
module tb_mem_bridge;

  logic clock;
  logic reset;

  int checks = 0;
  int errors = 0;

  logic [31:0] wrAddrQ[$];
  logic [31:0] wrDataQ[$];
  int          readReqs = 0;
  int          writesAtRead = 0;
  logic [31:0] lastReadAddr = '0;

  mem_bridge_if #(.DEPTH(4)) bus ();

  mem_bridge #(.DEPTH(4), .TIMEOUT(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory-side monitor: records every accepted request in bus order.
  always @(posedge clock) begin
    if (reset && bus.mem_valid && bus.mem_ready) begin
      if (bus.mem_we) begin
        wrAddrQ.push_back(bus.mem_addr);
        wrDataQ.push_back(bus.mem_wdata);
      end else begin
        readReqs++;
        lastReadAddr = bus.mem_addr;
        writesAtRead = wrAddrQ.size();
      end
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic applyStimulus(input logic req, input logic rw,
                               input logic [31:0] addr, input logic [31:0] wdata);
    bus.cpu_req   = req;
    bus.cpu_rw    = rw;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic clearLog();
    wrAddrQ.delete();
    wrDataQ.delete();
  endtask

  // One CPU read: counts stall cycles and returns rdata in the accept cycle.
  // delay<0 means memory never answers; readyAt<0 leaves mem_ready untouched.
  task automatic doRead(input logic [31:0] addr, input int delay, input logic [31:0] data,
                        input int readyAt, output int stalls, output logic [31:0] got);
    int  hs;
    bit  done;
    hs     = -1;
    stalls = 0;
    done   = 1'b0;
    got    = 'x;
    applyStimulus(1'b1, 1'b0, addr, 32'h0);
    for (int k = 0; k < 40 && !done; k++) begin
      if (readyAt >= 0) bus.mem_ready = (k >= readyAt);
      bus.mem_rvalid = (delay >= 0) && (hs >= 0) && (k == hs + delay);
      bus.mem_rdata  = bus.mem_rvalid ? data : 32'h0;
      #1;
      if (bus.cpu_stall) stalls++;
      else begin
        done = 1'b1;
        got  = bus.cpu_rdata;
      end
      if (bus.mem_valid && !bus.mem_we && bus.mem_ready) hs = k;
      tick();
    end
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    if (!done) checkOutput("readCompleted", 32'd0, 32'd1);
  endtask

  initial begin
    int          stalls;
    logic [31:0] got;
    int          savedReqs;

    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    repeat (2) tick();

    checkOutput("rstRdata", bus.cpu_rdata, 32'h0);
    checkOutput("rstStall", bus.cpu_stall, 32'h0);
    checkOutput("rstMemValid", bus.mem_valid, 32'h0);
    checkOutput("rstMemWe", bus.mem_we, 32'h0);
    checkOutput("rstMemAddr", bus.mem_addr, 32'h0);
    checkOutput("rstMemWdata", bus.mem_wdata, 32'h0);
    checkOutput("rstLevel", bus.wbuf_level, 32'h0);
    checkOutput("rstErr", bus.err, 32'h0);
    reset = 1'b1;
    tick();

    // Three posted writes with memory always ready.
    $display("[TB] posted writes");
    clearLog();
    bus.mem_ready = 1'b1;
    applyStimulus(1'b1, 1'b1, 32'h10, 32'h1); #1;
    checkOutput("w1Stall", bus.cpu_stall, 32'h0);
    tick();
    checkOutput("w1BusValid", bus.mem_valid, 32'h1);
    checkOutput("w1BusWe", bus.mem_we, 32'h1);
    checkOutput("w1BusAddr", bus.mem_addr, 32'h10);
    checkOutput("w1BusData", bus.mem_wdata, 32'h1);
    applyStimulus(1'b1, 1'b1, 32'h11, 32'h2); #1;
    checkOutput("w2Stall", bus.cpu_stall, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b1, 32'h12, 32'h3); #1;
    checkOutput("w3Stall", bus.cpu_stall, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) tick();
    checkOutput("wLevelEmpty", bus.wbuf_level, 32'h0);
    checkOutput("wBusIdle", bus.mem_valid, 32'h0);
    checkOutput("wCount", wrAddrQ.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      checkOutput("wOrderAddr", (i < wrAddrQ.size()) ? wrAddrQ[i] : 32'hFFFF_FFFF, 32'h10 + i);
      checkOutput("wOrderData", (i < wrDataQ.size()) ? wrDataQ[i] : 32'hFFFF_FFFF, 32'h1 + i);
    end

    // Fill the buffer with memory stalled, then one extra write.
    $display("[TB] buffer full");
    clearLog();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 32'h100 + i, 32'hA0 + i); #1;
      checkOutput("fillStall", bus.cpu_stall, 32'h0);
      tick();
    end
    applyStimulus(1'b1, 1'b1, 32'h104, 32'hA4); #1;
    checkOutput("fullStall", bus.cpu_stall, 32'h1);
    checkOutput("fullLevel", bus.wbuf_level, 32'd4);
    tick();
    bus.mem_ready = 1'b1; #1;
    checkOutput("fullStillStall", bus.cpu_stall, 32'h1);
    tick();
    checkOutput("fullAfterPopStall", bus.cpu_stall, 32'h0);
    checkOutput("fullAfterPopLevel", bus.wbuf_level, 32'd3);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (6) tick();
    checkOutput("fullDrained", bus.wbuf_level, 32'h0);
    checkOutput("fullCount", wrAddrQ.size(), 32'd5);
    for (int i = 0; i < 5; i++) begin
      checkOutput("fullOrderAddr", (i < wrAddrQ.size()) ? wrAddrQ[i] : 32'hFFFF_FFFF, 32'h100 + i);
      checkOutput("fullOrderData", (i < wrDataQ.size()) ? wrDataQ[i] : 32'hFFFF_FFFF, 32'hA0 + i);
    end

    // Plain read, rvalid three cycles after the handshake.
    $display("[TB] read");
    doRead(32'h40, 3, 32'hCAFE_0001, 0, stalls, got);
    checkOutput("rdStalls", stalls, 32'd5);
    checkOutput("rdData", got, 32'hCAFE_0001);
    checkOutput("rdErr", bus.err, 32'h0);
    checkOutput("rdReqAddr", lastReadAddr, 32'h40);

    // Memory never answers.
    $display("[TB] read timeout");
    doRead(32'h44, -1, 32'h0, 0, stalls, got);
    checkOutput("tmoStalls", stalls, 32'd10);
    checkOutput("tmoData", got, 32'hDEAD_BEEF);
    checkOutput("tmoErr", bus.err, 32'h1);
    doRead(32'h48, 1, 32'h1234_5678, 0, stalls, got);
    checkOutput("postTmoStalls", stalls, 32'd3);
    checkOutput("postTmoData", got, 32'h1234_5678);
    checkOutput("errSticky", bus.err, 32'h1);

    // Read of an address still sitting in the write buffer.
    $display("[TB] read after buffered write");
    clearLog();
    bus.mem_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, 32'h20, 32'h55); #1;
    checkOutput("hitWrStall", bus.cpu_stall, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    savedReqs = readReqs;
`ifdef MEM_BRIDGE_FWD_EN
    doRead(32'h20, 1, 32'h77, -1, stalls, got);
    checkOutput("fwdStalls", stalls, 32'd1);
    checkOutput("fwdData", got, 32'h55);
    checkOutput("fwdNoMemRead", readReqs, savedReqs);
    checkOutput("fwdStillBuffered", bus.wbuf_level, 32'd1);
    bus.mem_ready = 1'b1;
    repeat (4) tick();
    checkOutput("fwdDrained", bus.wbuf_level, 32'h0);
`else
    doRead(32'h20, 1, 32'h77, 2, stalls, got);
    checkOutput("drainStalls", stalls, 32'd6);
    checkOutput("drainData", got, 32'h77);
    checkOutput("drainOneRead", readReqs, savedReqs + 1);
    checkOutput("drainWriteFirst", writesAtRead, 32'd1);
    checkOutput("drainWrAddr", (wrAddrQ.size() > 0) ? wrAddrQ[0] : 32'hFFFF_FFFF, 32'h20);
`endif

    // Reset while a read waits for data with two writes buffered.
    $display("[TB] reset mid-read");
    bus.mem_ready = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h60, 32'h0);
    repeat (2) tick();
    applyStimulus(1'b1, 1'b1, 32'h70, 32'h1);
    tick();
    applyStimulus(1'b1, 1'b1, 32'h71, 32'h2);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h60, 32'h0); #1;
    checkOutput("midLevel", bus.wbuf_level, 32'd2);
    checkOutput("midStall", bus.cpu_stall, 32'h1);
    reset = 1'b0; #1;
    checkOutput("arstRdata", bus.cpu_rdata, 32'h0);
    checkOutput("arstStall", bus.cpu_stall, 32'h0);
    checkOutput("arstMemValid", bus.mem_valid, 32'h0);
    checkOutput("arstMemWe", bus.mem_we, 32'h0);
    checkOutput("arstMemAddr", bus.mem_addr, 32'h0);
    checkOutput("arstMemWdata", bus.mem_wdata, 32'h0);
    checkOutput("arstLevel", bus.wbuf_level, 32'h0);
    checkOutput("arstErr", bus.err, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hBAD0_BAD0;
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    tick();
    checkOutput("lateRvalidRdata", bus.cpu_rdata, 32'h0);
    checkOutput("lateRvalidLevel", bus.wbuf_level, 32'h0);
    checkOutput("lateRvalidBus", bus.mem_valid, 32'h0);
    doRead(32'h80, 2, 32'h600D_600D, 0, stalls, got);
    checkOutput("postRstStalls", stalls, 32'd4);
    checkOutput("postRstData", got, 32'h600D_600D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
